img_lk_gradient: RTL and testbench
==================================

IMG_LK_GRADIENT -- requirements
Module: img_lk_gradient

Interface
REQ-001 SHALL have parameter RAW_BITS, default 8: unsigned pixel width.
REQ-002 SHALL have parameter GRAD_BITS, default RAW_BITS+6: signed width of the diff and gradient outputs.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = clamp gradients to GRAD_BITS range; 0 = truncate to the low GRAD_BITS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cke, input, 1 bit: clock enable; all state advances only when cke=1.
REQ-007 SHALL have port s_valid, input, 1 bit: input window valid.
REQ-008 SHALL have port s_first, input, 1 bit: first pixel of a frame; qualified by s_valid.
REQ-009 SHALL have port s_mode, input, 2 bits: kernel select (0 Sobel, 1 Scharr, 2 Prewitt, 3 central difference).
REQ-010 SHALL have port in_raw, input, 3x3x2xRAW_BITS: window in [row][col][frame] order; frame 1 = current, frame 0 = previous.
REQ-011 SHALL have port m_valid, output, 1 bit: output valid.
REQ-012 SHALL have port m_first, output, 1 bit: delayed s_first.
REQ-013 SHALL have port m_raw, output, 2xRAW_BITS: centre pixel of both frames, delayed.
REQ-014 SHALL have ports m_diff, m_gradx and m_grady, output, GRAD_BITS signed each: temporal diff and spatial gradients.
REQ-015 SHALL have port m_sat, output, 1 bit: m_gradx or m_grady was clamped (SATURATE=1 only; otherwise 0).
REQ-016 SHALL have port m_sat_count, output, 32 bits: number of saturated valid pixels in the previous completed frame.

Function
REQ-017 SHALL form the per-position sum S[r][c] = in_raw[r][c][1] + in_raw[r][c][0], unsigned, RAW_BITS+1 bits.
REQ-018 SHALL compute row differences Dx[r] = S[r][2] - S[r][0] and column differences Dy[c] = S[2][c] - S[0][c], signed.
REQ-019 SHALL compute gradx = wo*(Dx[0]+Dx[2]) + wc*Dx[1] and grady = wo*(Dy[0]+Dy[2]) + wc*Dy[1].
REQ-020 SHALL use weights (wo,wc) of (1,2) for Sobel, (3,10) for Scharr, (1,1) for Prewitt and (0,1) for central difference.
REQ-021 SHALL compute all internal arithmetic at RAW_BITS+7 signed bits with no intermediate overflow.
REQ-022 SHALL reduce the internal result to GRAD_BITS at the final stage, clamping to [-2^(GRAD_BITS-1), 2^(GRAD_BITS-1)-1] when SATURATE=1.
REQ-023 SHALL output m_diff = in_raw[1][1][1] - in_raw[1][1][0], sign-extended to GRAD_BITS, or clamped when narrower and SATURATE=1.
REQ-024 SHALL latch s_mode into an active-mode register only when cke & s_valid & s_first.
REQ-025 SHALL apply the newly latched mode to the s_first pixel itself.
REQ-026 SHALL process all other pixels with the active mode.
REQ-027 SHALL carry the mode down the pipeline with each pixel, so that a mode change never affects pixels already in flight.
REQ-028 SHALL have a fixed latency of 4 cke-qualified cycles: an input sampled on cke edge N appears on the outputs after cke edge N+3.
REQ-029 SHALL carry s_valid and s_first with the data; m_first = 1 only when m_valid = 1.
REQ-030 SHALL hold all registers and outputs unchanged while cke = 0.
REQ-031 SHALL keep a frame counter that increments on each m_valid & m_sat.
REQ-032 SHALL, on m_valid & m_first, load m_sat_count with the counter value and restart the counter.
REQ-033 SHALL count that first pixel itself into the new frame.
REQ-034 SHALL saturate the frame counter at 2^32-1 rather than wrap.
REQ-035 SHALL ignore pixels with s_valid = 0 for mode latching and counting; their data path contents are don't-care.

Reset
REQ-036 SHALL, when reset_n = 0 at a clk edge (regardless of cke), clear the valid/first pipeline, active mode (0), frame counter and m_sat_count to 0.
REQ-037 SHALL drive m_valid = 0, m_first = 0 and m_sat = 0 from the cycle after reset.
REQ-038 SHALL drive data outputs m_raw, m_diff, m_gradx and m_grady to 0 on reset.
REQ-039 SHALL discard pixels in flight on reset; the first valid output after release is the first input accepted after release.

Verification
REQ-040 SHALL cover a flat image: all pixels 100, any mode -> m_gradx = m_grady = m_diff = 0, m_sat = 0.
REQ-041 SHALL cover a horizontal ramp: columns 0/10/20 in both frames, mode latched on first -> gradx 160 (Sobel), 640 (Scharr), 120 (Prewitt), 40 (central); grady 0.
REQ-042 SHALL cover temporal diff: centre frame1 = 200, frame0 = 50 -> m_diff = 150; swapped -> m_diff = -150.
REQ-043 SHALL cover saturation: GRAD_BITS = 10, Scharr, column 0 = 0, column 2 = 255 -> m_gradx = 511, m_sat = 1; frame of 5 such pixels then s_first -> m_sat_count = 5.
REQ-044 SHALL cover a mid-pipeline mode change: Sobel frame then s_first with Scharr on the next cycle -> earlier pixels keep Sobel values; Scharr applies from the first-flagged pixel.
REQ-045 SHALL cover cke gaps and reset: cke toggled 1/0 -> latency 4 cke edges and outputs stable while low; reset_n = 0 mid-stream -> m_valid = 0 next cycle, m_sat_count = 0.

Source files
------------

// File: rtl/img_lk_gradient.sv
// Lucas-Kanade front end: temporal difference and frame-summed spatial gradients
// over a 3x3 window, four-stage pipeline with selectable kernel and saturation stats.
module img_lk_gradient #(
  parameter int RAW_BITS  = 8,
  parameter int GRAD_BITS = RAW_BITS + 6,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cke,
  input  logic                                   s_valid,
  input  logic                                   s_first,
  input  logic [1:0]                             s_mode,
  input  logic [2:0][2:0][1:0][RAW_BITS-1:0]     in_raw,
  output logic                                   m_valid,
  output logic                                   m_first,
  output logic [1:0][RAW_BITS-1:0]               m_raw,
  output logic signed [GRAD_BITS-1:0]            m_diff,
  output logic signed [GRAD_BITS-1:0]            m_gradx,
  output logic signed [GRAD_BITS-1:0]            m_grady,
  output logic                                   m_sat,
  output logic [31:0]                            m_sat_count
);

  typedef enum logic [1:0] {SOBEL, SCHARR, PREWITT, CDIFF} mode_e;

  localparam int W  = RAW_BITS + 7;
  localparam int WX = ((W > GRAD_BITS) ? W : GRAD_BITS) + 1;
  localparam logic signed [WX-1:0] HI = (WX'(1) <<< (GRAD_BITS - 1)) - WX'(1);
  localparam logic signed [WX-1:0] LO = -HI - WX'(1);

  function automatic logic signed [W-1:0] zext(input logic [RAW_BITS:0] v);
    return signed'(W'(v));
  endfunction

  // Weights are built from shifts: Scharr 3*o = o+2o, 10*c = 8c+2c.
  function automatic logic signed [W-1:0] wsum(input mode_e m,
                                               input logic signed [W-1:0] o,
                                               input logic signed [W-1:0] c);
    case (m)
      SOBEL:   return o + (c <<< 1);
      SCHARR:  return o + (o <<< 1) + (c <<< 3) + (c <<< 1);
      PREWITT: return o + c;
      default: return c;
    endcase
  endfunction

  function automatic logic ovf(input logic signed [W-1:0] v);
    logic signed [WX-1:0] x;
    x = WX'(v);
    return SATURATE && ((x > HI) || (x < LO));
  endfunction

  function automatic logic signed [GRAD_BITS-1:0] reduce(input logic signed [W-1:0] v);
    logic signed [WX-1:0] x;
    x = WX'(v);
    if (SATURATE && (x > HI))      x = HI;
    else if (SATURATE && (x < LO)) x = LO;
    return x[GRAD_BITS-1:0];
  endfunction

  mode_e active_mode, cur_mode;
  assign cur_mode = (s_valid && s_first) ? mode_e'(s_mode) : active_mode;

  // Stage 1: per-position frame sums, centre diff.
  logic [2:0][2:0][RAW_BITS:0]   s1_sum;
  logic signed [W-1:0]           s1_diff;
  logic [1:0][RAW_BITS-1:0]      s1_raw;
  mode_e                         s1_mode;
  // Stage 2: outer/centre row and column difference terms.
  logic signed [W-1:0]           s2_ox, s2_cx, s2_oy, s2_cy, s2_diff;
  logic [1:0][RAW_BITS-1:0]      s2_raw;
  mode_e                         s2_mode;
  // Stage 3: weighted gradients at full internal width.
  logic signed [W-1:0]           s3_gx, s3_gy, s3_diff;
  logic [1:0][RAW_BITS-1:0]      s3_raw;
  logic                          s1_valid, s1_first, s2_valid, s2_first, s3_valid, s3_first;

  logic signed [W-1:0] dx [3];
  logic signed [W-1:0] dy [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dx[i] = zext(s1_sum[i][2]) - zext(s1_sum[i][0]);
      dy[i] = zext(s1_sum[2][i]) - zext(s1_sum[0][i]);
    end
  end

  // NOTE: datapath registers have no reset; the reset valid pipeline marks their contents don't-care.
  always_ff @(posedge clk) begin
    if (cke) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s1_sum[r][c] <= (RAW_BITS+1)'(in_raw[r][c][1]) + (RAW_BITS+1)'(in_raw[r][c][0]);
      s1_diff <= zext({1'b0, in_raw[1][1][1]}) - zext({1'b0, in_raw[1][1][0]});
      s1_raw  <= {in_raw[1][1][1], in_raw[1][1][0]};
      s1_mode <= cur_mode;

      s2_ox   <= dx[0] + dx[2];
      s2_cx   <= dx[1];
      s2_oy   <= dy[0] + dy[2];
      s2_cy   <= dy[1];
      s2_diff <= s1_diff;
      s2_raw  <= s1_raw;
      s2_mode <= s1_mode;

      s3_gx   <= wsum(s2_mode, s2_ox, s2_cx);
      s3_gy   <= wsum(s2_mode, s2_oy, s2_cy);
      s3_diff <= s2_diff;
      s3_raw  <= s2_raw;
    end
  end

  logic        sat_now;
  logic [31:0] sat_cnt;
  assign sat_now = ovf(s3_gx) || ovf(s3_gy);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_mode <= SOBEL;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s2_valid    <= 1'b0;
      s2_first    <= 1'b0;
      s3_valid    <= 1'b0;
      s3_first    <= 1'b0;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_sat       <= 1'b0;
      m_raw       <= '0;
      m_diff      <= '0;
      m_gradx     <= '0;
      m_grady     <= '0;
      sat_cnt     <= '0;
      m_sat_count <= '0;
    end else if (cke) begin
      if (s_valid && s_first) active_mode <= mode_e'(s_mode);
      s1_valid <= s_valid;
      s1_first <= s_valid && s_first;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s3_valid <= s2_valid;
      s3_first <= s2_first;

      m_valid  <= s3_valid;
      m_first  <= s3_first;
      m_sat    <= s3_valid && sat_now;
      m_raw    <= s3_raw;
      m_diff   <= reduce(s3_diff);
      m_gradx  <= reduce(s3_gx);
      m_grady  <= reduce(s3_gy);

      // The first pixel of a frame closes the previous frame and opens the new count.
      if (s3_valid) begin
        if (s3_first) begin
          m_sat_count <= sat_cnt;
          sat_cnt     <= {31'b0, sat_now};
        end else if (sat_now && (sat_cnt != '1)) begin
          sat_cnt <= sat_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_img_lk_gradient.sv
// Directed bench for img_lk_gradient: default-width instance plus a GRAD_BITS=10
// instance sharing the same stimulus, checked against hand-computed vectors.
module tb_img_lk_gradient;

  localparam int RB = 8;
  localparam int GW = RB + 6;
  localparam int GN = 10;

  typedef logic [2:0][2:0][1:0][RB-1:0] win_t;
  typedef struct {
    logic       valid;
    logic       first;
    logic [1:0] mode;
    win_t       win;
    int         gx;
    int         gy;
    int         diff;
    int         cnt_n;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cke = 1'b0;
  logic s_valid = 1'b0;
  logic s_first = 1'b0;
  logic [1:0] s_mode = 2'd0;
  win_t in_raw = '0;

  logic                  m_valid, m_first, m_sat;
  logic [1:0][RB-1:0]    m_raw;
  logic signed [GW-1:0]  m_diff, m_gradx, m_grady;
  logic [31:0]           m_sat_count;

  logic                  n_valid, n_first, n_sat;
  logic [1:0][RB-1:0]    n_raw;
  logic signed [GN-1:0]  n_diff, n_gradx, n_grady;
  logic [31:0]           n_sat_count;

  img_lk_gradient #(.RAW_BITS(RB)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_first(s_first),
    .s_mode(s_mode), .in_raw(in_raw), .m_valid(m_valid), .m_first(m_first),
    .m_raw(m_raw), .m_diff(m_diff), .m_gradx(m_gradx), .m_grady(m_grady),
    .m_sat(m_sat), .m_sat_count(m_sat_count)
  );

  img_lk_gradient #(.RAW_BITS(RB), .GRAD_BITS(GN), .SATURATE(1'b1)) dut_n (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_first(s_first),
    .s_mode(s_mode), .in_raw(in_raw), .m_valid(n_valid), .m_first(n_first),
    .m_raw(n_raw), .m_diff(n_diff), .m_gradx(n_gradx), .m_grady(n_grady),
    .m_sat(n_sat), .m_sat_count(n_sat_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vq[$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampb(input int v, input int bits);
    int hi, lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic win_t lin(input int b1, input int dx1, input int dy1,
                               input int b0, input int dx0, input int dy0);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        w[r][c][1] = RB'(b1 + c * dx1 + r * dy1);
        w[r][c][0] = RB'(b0 + c * dx0 + r * dy0);
      end
    return w;
  endfunction

  function automatic win_t cols(input int a, input int b, input int c);
    win_t w;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = {RB'(a), RB'(a)};
      w[r][1] = {RB'(b), RB'(b)};
      w[r][2] = {RB'(c), RB'(c)};
    end
    return w;
  endfunction

  function automatic win_t rows(input int a, input int b, input int c);
    win_t w;
    for (int k = 0; k < 3; k++) begin
      w[0][k] = {RB'(a), RB'(a)};
      w[1][k] = {RB'(b), RB'(b)};
      w[2][k] = {RB'(c), RB'(c)};
    end
    return w;
  endfunction

  function automatic vec_t mk(input logic v, input logic f, input logic [1:0] m,
                              input win_t w, input int gx, input int gy,
                              input int df, input int cn);
    vec_t t;
    t.valid = v; t.first = f; t.mode = m; t.win = w;
    t.gx = gx; t.gy = gy; t.diff = df; t.cnt_n = cn;
    return t;
  endfunction

  task automatic check_out(input vec_t v, input string tag);
    logic wsat, nsat;
    check({tag, " valid"}, m_valid, v.valid);
    check({tag, " n.valid"}, n_valid, v.valid);
    if (v.valid) begin
      wsat = (clampb(v.gx, GW) != v.gx) || (clampb(v.gy, GW) != v.gy);
      nsat = (clampb(v.gx, GN) != v.gx) || (clampb(v.gy, GN) != v.gy);
      check({tag, " gradx"}, m_gradx, v.gx);
      check({tag, " grady"}, m_grady, v.gy);
      check({tag, " diff"}, m_diff, v.diff);
      check({tag, " first"}, m_first, v.first);
      check({tag, " raw"}, m_raw, {v.win[1][1][1], v.win[1][1][0]});
      check({tag, " sat"}, m_sat, wsat);
      check({tag, " n.gradx"}, n_gradx, clampb(v.gx, GN));
      check({tag, " n.grady"}, n_grady, clampb(v.gy, GN));
      check({tag, " n.diff"}, n_diff, clampb(v.diff, GN));
      check({tag, " n.sat"}, n_sat, nsat);
    end
    if (v.cnt_n >= 0) check({tag, " n.sat_count"}, n_sat_count, v.cnt_n);
  endtask

  // Streams vq back to back; the output of vector k is sampled after the 4th edge.
  task automatic run_stream(input string tag);
    int n;
    n = vq.size();
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) begin
        s_valid = vq[k].valid; s_first = vq[k].first;
        s_mode = vq[k].mode;   in_raw = vq[k].win;
      end else begin
        s_valid = 1'b0; s_first = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 3) check_out(vq[k-3], $sformatf("%s[%0d]", tag, k - 3));
    end
    s_valid = 1'b0; s_first = 1'b0;
    vq.delete();
  endtask

  initial begin
    win_t hr, wa;
    hr = cols(0, 10, 20);

    // Reset state.
    reset_n = 1'b0; cke = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", m_valid, 1'b0);
    check("rst first", m_first, 1'b0);
    check("rst sat", m_sat, 1'b0);
    check("rst gradx", m_gradx, 0);
    check("rst grady", m_grady, 0);
    check("rst diff", m_diff, 0);
    check("rst raw", m_raw, 0);
    check("rst sat_count", m_sat_count, 0);
    check("rst n.valid", n_valid, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table: every vector is a frame start, so it latches its own mode.
    wa = lin(0, 0, 0, 0, 0, 0);
    wa[0][2] = {8'd30, 8'd30};
    vq.push_back(mk(1, 1, 0, lin(100, 0, 0, 100, 0, 0), 0, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, lin(100, 0, 0, 100, 0, 0), 0, 0, 0, -1));
    vq.push_back(mk(1, 1, 0, hr, 160, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, hr, 640, 0, 0, -1));
    vq.push_back(mk(1, 1, 2, hr, 120, 0, 0, -1));
    vq.push_back(mk(1, 1, 3, hr, 40, 0, 0, -1));
    vq.push_back(mk(1, 1, 0, rows(0, 10, 20), 0, 160, 0, -1));
    vq.push_back(mk(1, 1, 1, rows(0, 10, 20), 0, 640, 0, -1));
    vq.push_back(mk(1, 1, 2, lin(0, 10, 10, 0, 10, 10), 120, 120, 0, -1));
    vq.push_back(mk(1, 1, 0, lin(200, 0, 0, 50, 0, 0), 0, 0, 150, -1));
    vq.push_back(mk(1, 1, 0, lin(50, 0, 0, 200, 0, 0), 0, 0, -150, -1));
    vq.push_back(mk(1, 1, 0, lin(0, 10, 0, 0, 0, 0), 80, 0, 10, -1));
    vq.push_back(mk(1, 1, 0, wa, 60, -60, 0, -1));
    vq.push_back(mk(1, 1, 1, wa, 180, -180, 0, -1));
    vq.push_back(mk(1, 1, 2, wa, 60, -60, 0, -1));
    vq.push_back(mk(1, 1, 3, wa, 0, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, cols(0, 128, 255), 8160, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, cols(255, 128, 0), -8160, 0, 0, -1));
    vq.push_back(mk(1, 1, 0, rows(0, 128, 255), 0, 2040, 0, -1));
    run_stream("tbl");

    // Mode change with pixels in flight; invalid first-flagged beats never latch.
    vq.push_back(mk(1, 1, 0, hr, 160, 0, 0, -1));
    vq.push_back(mk(1, 0, 1, hr, 160, 0, 0, -1));
    vq.push_back(mk(1, 0, 2, hr, 160, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, hr, 640, 0, 0, -1));
    vq.push_back(mk(1, 0, 3, hr, 640, 0, 0, -1));
    vq.push_back(mk(0, 1, 3, hr, 0, 0, 0, -1));
    vq.push_back(mk(1, 0, 0, hr, 640, 0, 0, -1));
    run_stream("mode");

    // Saturation frame of 5, then two frame starts to read back the counts.
    vq.push_back(mk(1, 1, 1, cols(0, 128, 255), 8160, 0, 0, -1));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 0, 0, cols(0, 128, 255), 8160, 0, 0, -1));
    vq.push_back(mk(1, 1, 1, cols(0, 128, 255), 8160, 0, 0, 5));
    vq.push_back(mk(1, 1, 0, lin(100, 0, 0, 100, 0, 0), 0, 0, 0, 1));
    run_stream("satcnt");
    check("wide sat_count", m_sat_count, 0);

    // Clock-enable gaps: one pixel needs four cke edges; outputs hold while cke is low.
    repeat (4) @(posedge clk);
    #1;
    check("gap idle", m_valid, 1'b0);
    in_raw = hr; s_mode = 2'd0; s_valid = 1'b1; s_first = 1'b1; cke = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      cke = 1'b0; s_valid = 1'b1; s_first = 1'b1; s_mode = 2'd3;
      @(posedge clk); #1;
      check($sformatf("gap low%0d valid", k), m_valid, 1'b0);
      s_valid = 1'b0; s_first = 1'b0; cke = 1'b1;
      @(posedge clk); #1;
      check($sformatf("gap high%0d valid", k), m_valid, k == 3);
    end
    check("gap gradx", m_gradx, 160);
    cke = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold valid", m_valid, 1'b1);
    check("hold gradx", m_gradx, 160);
    check("hold first", m_first, 1'b1);
    cke = 1'b1;
    vq.push_back(mk(1, 0, 0, hr, 160, 0, 0, -1));
    run_stream("gapmode");

    // Reset mid-stream with cke low: state clears and in-flight pixels vanish.
    vq.push_back(mk(1, 1, 1, cols(0, 128, 255), 8160, 0, 0, -1));
    vq.push_back(mk(1, 1, 0, lin(100, 0, 0, 100, 0, 0), 0, 0, 0, 1));
    run_stream("prerst");
    in_raw = hr; s_mode = 2'd1; s_valid = 1'b1; s_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0; cke = 1'b0;
    @(posedge clk); #1;
    check("mrst valid", m_valid, 1'b0);
    check("mrst first", m_first, 1'b0);
    check("mrst gradx", m_gradx, 0);
    check("mrst n.sat_count", n_sat_count, 0);
    reset_n = 1'b1; cke = 1'b1; s_valid = 1'b0; s_first = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-rst idle%0d", k), m_valid, 1'b0);
    end
    vq.push_back(mk(1, 0, 1, hr, 160, 0, 0, -1));
    run_stream("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
